dram_cmd_gen: RTL

DRAM_CMD_GEN -- requirements
Module: dram_cmd_gen

---
 rtl/dram_cmd_gen_if.sv | 33 +++
 rtl/dram_cmd_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dram_cmd_gen_if                                                 |
// | Brief    : Request/command bundle between controller queue and cmd gen.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface dram_cmd_gen_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [35:0] req_addr;
  logic [2:0]  cmd_code;
  logic        cmd_channel;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [5:0]  cmd_col;
  logic        err_illegal;
  logic [15:0] done_cnt;

  modport master (
    output req_valid, req_op, req_addr,
    input  req_ready, cmd_code, cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col,
    input  err_illegal, done_cnt
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    output req_ready, cmd_code, cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col,
    output err_illegal, done_cnt
  );
endinterface
`default_nettype wire

// File: rtl/dram_cmd_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dram_cmd_gen                                                    |
// | Brief    : Single-request ACT/CAS/PRE sequencer with one shared timer.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dram_cmd_gen #(
  parameter int T_RCD = 39,
  parameter int T_RTP = 18,
  parameter int T_WR  = 48,
  parameter int T_RP  = 39
) (
  input  logic          clk,
  input  logic          rst,
  dram_cmd_gen_if.slave bus
);

  localparam int c_MAX_A = (T_RCD > T_RTP) ? T_RCD : T_RTP;
  localparam int c_MAX_B = (T_WR > T_RP) ? T_WR : T_RP;
  localparam int c_MAXP  = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int TW      = $clog2(c_MAXP + 1);

  // Timer loads: a wait state lasts (load + 1) cycles, the two command
  // cycles on either side of each gap account for the rest of the interval.
  localparam logic [TW-1:0] c_RCD_LD = TW'((T_RCD > 2) ? T_RCD - 3 : 0);
  localparam logic [TW-1:0] c_RTP_LD = TW'((T_RTP > 2) ? T_RTP - 3 : 0);
  localparam logic [TW-1:0] c_WR_LD  = TW'((T_WR  > 2) ? T_WR  - 3 : 0);
  localparam logic [TW-1:0] c_RP_LD  = TW'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam bit c_RCD_WAIT = (T_RCD > 2);
  localparam bit c_RTP_WAIT = (T_RTP > 2);
  localparam bit c_WR_WAIT  = (T_WR  > 2);
  localparam bit c_RP_WAIT  = (T_RP  > 1);

  localparam logic [2:0] c_CMD_NOP  = 3'd0;
  localparam logic [2:0] c_CMD_ACT0 = 3'd1;
  localparam logic [2:0] c_CMD_ACT1 = 3'd2;
  localparam logic [2:0] c_CMD_RD0  = 3'd3;
  localparam logic [2:0] c_CMD_RD1  = 3'd4;
  localparam logic [2:0] c_CMD_WR0  = 3'd5;
  localparam logic [2:0] c_CMD_WR1  = 3'd6;
  localparam logic [2:0] c_CMD_PRE  = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ACT0     = 4'd1,
    S_ACT1     = 4'd2,
    S_WAIT_RCD = 4'd3,
    S_CAS0     = 4'd4,
    S_CAS1     = 4'd5,
    S_WAIT_PRE = 4'd6,
    S_PRE      = 4'd7,
    S_WAIT_RP  = 4'd8
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic            wr_q;
  logic [2:0]      cmd_q;
  logic            ready_q;
  logic            err_q;
  logic [15:0]     done_cnt_q;
  logic            chan_q;
  logic [2:0]      bg_q;
  logic [1:0]      bank_q;
  logic [15:0]     row_q;
  logic [5:0]      col_q;

  logic [2:0]      w_cas0;
  logic [2:0]      w_cas1;
  logic            w_pre_wait;
  logic [TW-1:0]   w_pre_ld;

  assign w_cas0     = wr_q ? c_CMD_WR0 : c_CMD_RD0;
  assign w_cas1     = wr_q ? c_CMD_WR1 : c_CMD_RD1;
  assign w_pre_wait = wr_q ? c_WR_WAIT : c_RTP_WAIT;
  assign w_pre_ld   = wr_q ? c_WR_LD : c_RTP_LD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      wr_q       <= 1'b0;
      cmd_q      <= c_CMD_NOP;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      done_cnt_q <= 16'd0;
      chan_q     <= 1'b0;
      bg_q       <= 3'd0;
      bank_q     <= 2'd0;
      row_q      <= 16'd0;
      col_q      <= 6'd0;
    end else begin
      cmd_q <= c_CMD_NOP;
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            chan_q <= bus.req_addr[6];
            bg_q   <= bus.req_addr[9:7];
            bank_q <= bus.req_addr[11:10];
            row_q  <= bus.req_addr[33:18];
            col_q  <= bus.req_addr[17:12];
            // Illegal ops are swallowed here; the block never leaves IDLE.
            if (bus.req_op == 2'd3) begin
              err_q <= 1'b1;
            end else begin
              wr_q    <= (bus.req_op == 2'd1);
              state_q <= S_ACT0;
              cmd_q   <= c_CMD_ACT0;
              ready_q <= 1'b0;
            end
          end
        end
        S_ACT0: begin
          state_q <= S_ACT1;
          cmd_q   <= c_CMD_ACT1;
        end
        S_ACT1: begin
          if (c_RCD_WAIT) begin
            state_q <= S_WAIT_RCD;
            timer_q <= c_RCD_LD;
          end else begin
            state_q <= S_CAS0;
            cmd_q   <= w_cas0;
          end
        end
        S_WAIT_RCD: begin
          if (timer_q == '0) begin
            state_q <= S_CAS0;
            cmd_q   <= w_cas0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_CAS0: begin
          state_q <= S_CAS1;
          cmd_q   <= w_cas1;
        end
        S_CAS1: begin
          if (w_pre_wait) begin
            state_q <= S_WAIT_PRE;
            timer_q <= w_pre_ld;
          end else begin
            state_q    <= S_PRE;
            cmd_q      <= c_CMD_PRE;
            done_cnt_q <= done_cnt_q + 16'd1;
          end
        end
        S_WAIT_PRE: begin
          if (timer_q == '0) begin
            state_q    <= S_PRE;
            cmd_q      <= c_CMD_PRE;
            done_cnt_q <= done_cnt_q + 16'd1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_PRE: begin
          if (c_RP_WAIT) begin
            state_q <= S_WAIT_RP;
            timer_q <= c_RP_LD;
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_WAIT_RP: begin
          if (timer_q == '0) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.cmd_code    = cmd_q;
  assign bus.cmd_channel = chan_q;
  assign bus.cmd_bg      = bg_q;
  assign bus.cmd_bank    = bank_q;
  assign bus.cmd_row     = row_q;
  assign bus.cmd_col     = col_q;
  assign bus.err_illegal = err_q;
  assign bus.done_cnt    = done_cnt_q;

endmodule
`default_nettype wire
